axis_prio_sched_mux: RTL

- N-channel, packet-atomic AXI-Stream scheduler and mux in one block; replaces the fixed 3-input mux plus external select/enable scheduler.
- Sits between the per-priority axis_fifo instances and the TX path.
- Strict priority: channel 0 is highest. An optional anti-starvation guard forces service of a low-priority channel after it has been bypassed too many times.
- Exposes the current grant and per-channel starvation events for status and debug.

---
 rtl/axis_prio_sched_mux_if.sv | 16 +
 rtl/axis_prio_sched_mux.sv | 128 ++++++++++++
 2 files changed

// File: rtl/axis_prio_sched_mux_if.sv
// Bundled AXI-Stream signals for one or more lanes; lane i occupies slice i of each vector.
// The scheduler takes the multi-lane inputs on its slave modport and drives one lane on master.
interface axis_prio_sched_mux_if #(
  parameter int unsigned LANES      = 1,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) ();
  logic [LANES*DATA_WIDTH-1:0] tdata;
  logic [LANES*KEEP_WIDTH-1:0] tkeep;
  logic [LANES-1:0]            tvalid;
  logic [LANES-1:0]            tready;
  logic [LANES-1:0]            tlast;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_prio_sched_mux.sv
// Packet-atomic strict-priority AXI-Stream scheduler and mux with an optional anti-starvation
// guard; channel 0 has the highest priority and a granted packet always runs to tlast.
module axis_prio_sched_mux #(
  parameter int unsigned N_CH         = 3,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned STARVE_LIMIT = 16,
  parameter int unsigned CNT_WIDTH    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1,
  parameter int unsigned IDX_WIDTH    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  axis_prio_sched_mux_if.slave     s_axis,
  axis_prio_sched_mux_if.master    m_axis,
  output logic                     grant_active,
  output logic [IDX_WIDTH-1:0]     grant_idx,
  output logic [N_CH-1:0]          starve_evt
);

  localparam logic [CNT_WIDTH-1:0] Limit = CNT_WIDTH'(STARVE_LIMIT);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   grant_idx_q, grant_idx_d;
  logic [N_CH-1:0]        starve_evt_q, starve_evt_d;
  logic [CNT_WIDTH-1:0]   cnt_q [N_CH];
  logic [CNT_WIDTH-1:0]   cnt_d [N_CH];

  logic                   busy;
  logic                   g_valid;
  logic                   g_last;
  logic                   pkt_end;
  logic                   prio_hit, starve_hit;
  logic [IDX_WIDTH-1:0]   prio_idx, starve_idx;

  assign busy    = (state_q == StBusy);
  assign g_valid = s_axis.tvalid[grant_idx_q];
  assign g_last  = s_axis.tlast[grant_idx_q];
  assign pkt_end = busy & g_valid & m_axis.tready[0] & g_last;

  // Lowest-index candidates for both the priority path and the starvation path.
  always_comb begin
    prio_hit   = 1'b0;
    prio_idx   = '0;
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (s_axis.tvalid[i] && !prio_hit) begin
        prio_hit = 1'b1;
        prio_idx = IDX_WIDTH'(i);
      end
      if ((STARVE_LIMIT > 0) && s_axis.tvalid[i] && (cnt_q[i] >= Limit) && !starve_hit) begin
        starve_hit = 1'b1;
        starve_idx = IDX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    m_axis.tdata  = s_axis.tdata[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
    m_axis.tkeep  = s_axis.tkeep[grant_idx_q*KEEP_WIDTH +: KEEP_WIDTH];
    m_axis.tvalid = busy & g_valid;
    m_axis.tlast  = busy & g_last;
    s_axis.tready = '0;
    if (busy) begin
      s_axis.tready[grant_idx_q] = m_axis.tready[0];
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    starve_evt_d = '0;
    cnt_d        = cnt_q;
    case (state_q)
      StIdle: begin
        if (enable && prio_hit) begin
          state_d = StBusy;
          if (starve_hit) begin
            grant_idx_d              = starve_idx;
            starve_evt_d[starve_idx] = 1'b1;
          end else begin
            grant_idx_d = prio_idx;
          end
        end
      end
      StBusy: begin
        if (pkt_end) begin
          state_d = StIdle;
          if (STARVE_LIMIT > 0) begin
            // Served channel restarts; every waiting channel records one more bypass.
            for (int unsigned i = 0; i < N_CH; i++) begin
              if (IDX_WIDTH'(i) == grant_idx_q) begin
                cnt_d[i] = '0;
              end else if (s_axis.tvalid[i] && (cnt_q[i] != Limit)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_idx_q  <= '0;
      starve_evt_q <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      starve_evt_q <= starve_evt_d;
      cnt_q        <= cnt_d;
    end
  end

  assign grant_active = busy;
  assign grant_idx    = grant_idx_q;
  assign starve_evt   = starve_evt_q;

endmodule
